// File: rtl/matrix_op_sequencer_if.sv
// Decoder and matrix-memory bus of the matrix coprocessor sequencer.
// Command, operand-read, result-write and status signals.
interface matrix_op_sequencer_if;
  logic              start;
  logic        [2:0] opcode;
  logic        [2:0] size;
  logic signed [7:0] scalar;
  logic        [4:0] a_addr;
  logic        [4:0] b_addr;
  logic signed [7:0] a_data;
  logic signed [7:0] b_data;
  logic        [4:0] c_addr;
  logic signed [7:0] c_wdata;
  logic              c_we;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              err;

  modport master (
    output start, opcode, size, scalar,
    output a_data, b_data,
    input  a_addr, b_addr,
    input  c_addr, c_wdata, c_we,
    input  busy, done, ovf, err
  );

  modport slave (
    input  start, opcode, size, scalar,
    input  a_data, b_data,
    output a_addr, b_addr,
    output c_addr, c_wdata, c_we,
    output busy, done, ovf, err
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// Matrix coprocessor sequencer: walks 5x5 A/B memories and
// writes ADD/SUB/SCALE/TRANS/MATMUL results into C.
module matrix_op_sequencer (
  input logic                  clk,
  input logic                  reset,
  matrix_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MAC,
    WRITE,
    DONE
  } state_t;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_SCALE = 3'd2;
  localparam logic [2:0] OP_TRANS = 3'd3;
  localparam logic [2:0] OP_MM    = 3'd4;

  state_t state, state_n;

  logic        [2:0]  op_q, op_n;
  logic        [2:0]  n_q, n_n;
  logic signed [7:0]  sc_q, sc_n;
  logic        [2:0]  i, j, k;
  logic        [2:0]  i_n, j_n, k_n;
  logic signed [19:0] acc, acc_n;
  logic        [4:0]  a_addr_q, a_addr_n;
  logic        [4:0]  b_addr_q, b_addr_n;
  logic               ovf_q, ovf_n;
  logic               err_q, err_n;
  logic               load;
  logic               legal;
  logic               last;

  logic signed [8:0]  add9;
  logic signed [8:0]  sub9;
  logic signed [15:0] sprod;
  logic signed [15:0] mprod;
  logic signed [19:0] res;
  logic               sat_hi;
  logic               sat_lo;
  logic signed [7:0]  sat8;

  function automatic logic [4:0] rc(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return {r, 2'b00} + {2'b00, r} + {2'b00, c};
  endfunction

  assign legal = (bus.opcode <= OP_MM) &&
                 (bus.size != 3'd0) &&
                 (bus.size <= 3'd5);

  assign last = (i == n_q - 3'd1) && (j == n_q - 3'd1);

  assign add9  = {bus.a_data[7], bus.a_data} +
                 {bus.b_data[7], bus.b_data};
  assign sub9  = {bus.a_data[7], bus.a_data} -
                 {bus.b_data[7], bus.b_data};
  assign sprod = 16'(bus.a_data) * 16'(sc_q);
  assign mprod = 16'(bus.a_data) * 16'(bus.b_data);

  always_comb begin
    res = '0;
    unique case (1'b1)
      (op_q == OP_ADD):   res = 20'(add9);
      (op_q == OP_SUB):   res = 20'(sub9);
      (op_q == OP_SCALE): res = 20'(sprod);
      (op_q == OP_TRANS): res = 20'(bus.a_data);
      (op_q == OP_MM):    res = acc;
      default:            res = '0;
    endcase
  end

  assign sat_hi = res > 20'sd127;
  assign sat_lo = res < -20'sd128;
  assign sat8   = sat_hi ? 8'sd127 :
                  sat_lo ? -8'sd128 :
                  res[7:0];

  always_comb begin
    state_n = state;
    op_n    = op_q;
    n_n     = n_q;
    sc_n    = sc_q;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    acc_n   = acc;
    ovf_n   = ovf_q;
    err_n   = err_q;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          op_n  = bus.opcode;
          n_n   = bus.size;
          sc_n  = bus.scalar;
          i_n   = '0;
          j_n   = '0;
          k_n   = '0;
          acc_n = '0;
          ovf_n = 1'b0;
          err_n = !legal;
          if (legal) begin
            state_n = READ;
            load    = 1'b1;
          end else begin
            state_n = DONE;
          end
        end
      end
      READ: begin
        state_n = (op_q == OP_MM) ? MAC : WRITE;
      end
      MAC: begin
        acc_n = acc + 20'(mprod);
        if (k < n_q - 3'd1) begin
          k_n     = k + 3'd1;
          state_n = READ;
          load    = 1'b1;
        end else begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        ovf_n = ovf_q | sat_hi | sat_lo;
        k_n   = '0;
        acc_n = '0;
        if (j == n_q - 3'd1) begin
          j_n = '0;
          i_n = i + 3'd1;
        end else begin
          j_n = j + 3'd1;
        end
        if (last) begin
          state_n = DONE;
        end else begin
          state_n = READ;
          load    = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // operand addresses follow the counters as they enter READ
  always_comb begin
    a_addr_n = a_addr_q;
    b_addr_n = b_addr_q;
    if (load) begin
      unique case (1'b1)
        (op_n == OP_TRANS): begin
          a_addr_n = rc(j_n, i_n);
          b_addr_n = rc(i_n, j_n);
        end
        (op_n == OP_MM): begin
          a_addr_n = rc(i_n, k_n);
          b_addr_n = rc(k_n, j_n);
        end
        default: begin
          a_addr_n = rc(i_n, j_n);
          b_addr_n = rc(i_n, j_n);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      op_q     <= '0;
      n_q      <= '0;
      sc_q     <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      n_q      <= n_n;
      sc_q     <= sc_n;
      i        <= i_n;
      j        <= j_n;
      k        <= k_n;
      acc      <= acc_n;
      a_addr_q <= a_addr_n;
      b_addr_q <= b_addr_n;
      ovf_q    <= ovf_n;
      err_q    <= err_n;
    end
  end

  assign bus.a_addr  = a_addr_q;
  assign bus.b_addr  = b_addr_q;
  assign bus.c_we    = (state == WRITE);
  assign bus.c_addr  = (state == WRITE) ? rc(i, j) : '0;
  assign bus.c_wdata = (state == WRITE) ? sat8 : '0;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.ovf     = ovf_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Bench for matrix_op_sequencer: memory models, command
// table, hand-written corner cases and a random run vs a model.
module tb_matrix_op_sequencer;

  logic clk;
  logic reset;

  matrix_op_sequencer_if bus();

  matrix_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0] memA [25];
  logic signed [7:0] memB [25];
  logic signed [7:0] memC [25];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    int op;
    int n;
    int k;
    int lat;
  } vec_t;
  vec_t tbl[11];

  int ex_addr[25];
  int ex_data[25];
  int ex_cyc[25];
  int ex_cnt;
  int ex_ovf;
  int ex_err;
  int ex_lat;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.a_data <= memA[bus.a_addr];
    bus.b_data <= memB[bus.b_addr];
    if (bus.c_we) memC[bus.c_addr] <= bus.c_wdata;
  end

  always @(negedge clk) begin
    if (bus.c_we)
      wq.push_back('{cyc, int'(bus.c_addr), int'(bus.c_wdata)});
    if (bus.busy && (bus.a_addr > 24 || bus.b_addr > 24 ||
        (bus.c_we && bus.c_addr > 24))) begin
      errors++;
      $display("FAIL addr_range a=%0d b=%0d c=%0d max 24",
               bus.a_addr, bus.b_addr, bus.c_addr);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int outs();
    return int'({bus.a_addr, bus.b_addr, bus.c_addr, bus.c_wdata,
                 bus.c_we, bus.busy, bus.done, bus.ovf, bus.err});
  endfunction

  // Reference: result matrix, write order/cycle, flags and latency
  function automatic void model(input int op, input int n, input int k);
    logic signed [7:0] ks;
    int v;
    ks = 8'(k);
    ex_cnt = 0;
    ex_ovf = 0;
    ex_err = !(op >= 0 && op <= 4 && n >= 1 && n <= 5);
    if (ex_err) begin
      ex_lat = 1;
      return;
    end
    ex_lat = (op == 4) ? n * n * (2 * n + 1) + 1 : 2 * n * n + 1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (op)
          0: v = int'(memA[i*5+j]) + int'(memB[i*5+j]);
          1: v = int'(memA[i*5+j]) - int'(memB[i*5+j]);
          2: v = int'(memA[i*5+j]) * int'(ks);
          3: v = int'(memA[j*5+i]);
          default: begin
            v = 0;
            for (int t = 0; t < n; t++)
              v += int'(memA[i*5+t]) * int'(memB[t*5+j]);
          end
        endcase
        if (v > 127) begin
          v = 127;
          ex_ovf = 1;
        end else if (v < -128) begin
          v = -128;
          ex_ovf = 1;
        end
        ex_addr[ex_cnt] = i * 5 + j;
        ex_data[ex_cnt] = v;
        ex_cyc[ex_cnt]  = (op == 4) ? (ex_cnt + 1) * (2 * n + 1)
                                    : 2 + 2 * ex_cnt;
        ex_cnt++;
      end
    end
  endfunction

  task automatic run_cmd(input string nm, input int op, input int n,
                         input int k, input int lat, input bit noise);
    int t0, dc, d_ovf, d_err, nw;
    bit got;
    model(op, n, k);
    if (lat < 0) lat = ex_lat;
    wq.delete();
    bus.start  = 1'b1;
    bus.opcode = 3'(op);
    bus.size   = 3'(n);
    bus.scalar = 8'(k);
    t0 = cyc;
    got = 1'b0;
    dc = 0;
    d_ovf = 0;
    d_err = 0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        dc = cyc;
        d_ovf = int'(bus.ovf);
        d_err = int'(bus.err);
      end
      bus.start = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        bus.opcode = 3'($urandom);
        bus.size   = 3'($urandom);
        bus.scalar = 8'($urandom);
      end
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    chk({nm, "_done_lat"}, dc - t0, lat);
    chk({nm, "_err"}, d_err, ex_err);
    chk({nm, "_ovf"}, d_ovf, ex_ovf);
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_idle_after"}, int'(bus.busy), 0);
    chk({nm, "_ovf_hold"}, int'(bus.ovf), ex_ovf);
    chk({nm, "_nwrites"}, wq.size(), ex_cnt);
    nw = (wq.size() < ex_cnt) ? wq.size() : ex_cnt;
    for (int w = 0; w < nw; w++) begin
      chk({nm, "_waddr"}, wq[w].addr, ex_addr[w]);
      chk({nm, "_wdata"}, wq[w].data, ex_data[w]);
      chk({nm, "_wcyc"}, wq[w].cyc - t0, ex_cyc[w]);
    end
  endtask

  task automatic rand_mem();
    foreach (memA[x]) memA[x] = 8'($urandom);
    foreach (memB[x]) memB[x] = 8'($urandom);
  endtask

  initial begin
    int t0;
    tbl[0]  = '{5, 2, 0, 1};
    tbl[1]  = '{7, 3, 0, 1};
    tbl[2]  = '{0, 0, 0, 1};
    tbl[3]  = '{1, 6, 0, 1};
    tbl[4]  = '{2, 7, 9, 1};
    tbl[5]  = '{0, 1, 0, 3};
    tbl[6]  = '{3, 3, 0, 19};
    tbl[7]  = '{4, 1, 0, 4};
    tbl[8]  = '{4, 3, 0, 64};
    tbl[9]  = '{2, 4, 5, 33};
    tbl[10] = '{4, 5, 0, 276};

    foreach (memA[x]) begin
      memA[x] = '0;
      memB[x] = '0;
      memC[x] = '0;
    end
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.size   = '0;
    bus.scalar = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    reset = 1'b1;
    @(negedge clk);

    rand_mem();
    foreach (tbl[v])
      run_cmd($sformatf("tbl%0d", v), tbl[v].op, tbl[v].n,
              tbl[v].k, tbl[v].lat, 1'b0);

    memA[0] = 1;  memA[1] = 2;  memA[5] = 3;  memA[6] = 4;
    memB[0] = 10; memB[1] = 20; memB[5] = 30; memB[6] = 40;
    run_cmd("add2", 0, 2, 0, 9, 1'b0);
    chk("add2_c0", int'(memC[0]), 11);
    chk("add2_c1", int'(memC[1]), 22);
    chk("add2_c5", int'(memC[5]), 33);
    chk("add2_c6", int'(memC[6]), 44);

    memA[0] = 100;
    memB[0] = -100;
    run_cmd("sub_sat", 1, 1, 0, 3, 1'b0);
    chk("sub_sat_c0", int'(memC[0]), 127);

    memA[0] = -64;
    run_cmd("scale_sat", 2, 1, 3, 3, 1'b0);
    chk("scale_sat_c0", int'(memC[0]), -128);

    foreach (memA[x]) memA[x] = 8'(x);
    run_cmd("trans5", 3, 5, 0, 51, 1'b1);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        chk("trans5_c", int'(memC[i*5+j]), j * 5 + i);

    memA[0] = 1; memA[1] = 2; memA[5] = 3; memA[6] = 4;
    memB[0] = 5; memB[1] = 6; memB[5] = 7; memB[6] = 8;
    run_cmd("mm2", 4, 2, 0, 21, 1'b0);
    chk("mm2_c0", int'(memC[0]), 19);
    chk("mm2_c1", int'(memC[1]), 22);
    chk("mm2_c5", int'(memC[5]), 43);
    chk("mm2_c6", int'(memC[6]), 50);

    // reset in the middle of a MATMUL
    wq.delete();
    bus.start  = 1'b1;
    bus.opcode = 3'd4;
    bus.size   = 3'd2;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 7) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_outs", outs(), 0);
    reset = 1'b1;
    chk("midrst_writes_before", wq.size(), 1);
    repeat (30) @(negedge clk);
    chk("midrst_no_more_writes", wq.size(), 1);
    chk("midrst_idle", int'(bus.busy), 0);
    run_cmd("after_rst", 4, 2, 0, 21, 1'b1);

    for (int r = 0; r < 30; r++) begin
      rand_mem();
      run_cmd("rnd", $urandom_range(0, 4), $urandom_range(1, 5),
              $urandom_range(0, 255), -1, 1'b1);
    end
    rand_mem();
    run_cmd("rnd_ill", $urandom_range(5, 7), $urandom_range(1, 5),
            0, -1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
